// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master
//
// Purpose: shifts one DATA_WIDTH-bit word out on spi_mosi while capturing spi_miso.
// CPOL, CPHA, bit order and the target slave are chosen per transfer.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   start                 transfer request; accepted only in IDLE
//   datain, cs_sel        transmit word and target slave, latched on accept
//   cpol, cpha, lsb_first transfer mode, latched on accept
//   spi_miso              serial data from the slave
//   busy, done            transfer in progress / one-cycle completion pulse
//   dataout               received word, updated when done pulses
//   spi_cs_l              active-low chip selects
//   spi_sclk, spi_mosi    serial clock and data to the slave
//   bit_count             bits not yet sampled in the current transfer
module spi_master_param #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 2,
   parameter int NUM_CS     = 1,
   localparam int CS_SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
   localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] datain,
   input  logic [CS_SEL_W-1:0]   cs_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic                  spi_miso,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic [NUM_CS-1:0]     spi_cs_l,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   output logic [CNT_W-1:0]      bit_count
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      LEAD,
      XFER,
      TRAIL
   } state_t;

   state_t                state;
   logic [DIV_W-1:0]      div_cnt;
   logic [EDGE_W-1:0]     edge_cnt;
   logic [DATA_WIDTH-1:0] tx_sh;
   logic [DATA_WIDTH-1:0] rx_sh;
   logic                  cpol_q;
   logic                  cpha_q;
   logic                  lsb_q;
   logic                  tick;
   logic                  leading;
   logic                  sample;

   // The divider wraps at CLK_DIV-1; with CLK_DIV=1 every cycle is a tick.
   assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
   // edge_cnt holds toggles already made, so an even count means the next toggle is odd (leading).
   assign leading = ~edge_cnt[0];
   assign sample  = leading ^ cpha_q;

   function automatic logic head(input logic [DATA_WIDTH-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift(input logic [DATA_WIDTH-1:0] v, input logic lsb);
      return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
   endfunction

   // Out-of-range selects leave every chip select deasserted.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
      logic [NUM_CS-1:0] m;
      m = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (int'(sel) == i) m[i] = 1'b0;
      end
      return m;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         edge_cnt  <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dataout   <= '0;
         spi_cs_l  <= '1;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b0;
         bit_count <= CNT_W'(DATA_WIDTH);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               div_cnt  <= '0;
               spi_cs_l <= '1;
               spi_sclk <= cpol_q;
               if (start) begin
                  tx_sh     <= datain;
                  cpol_q    <= cpol;
                  cpha_q    <= cpha;
                  lsb_q     <= lsb_first;
                  spi_sclk  <= cpol;
                  spi_cs_l  <= cs_decode(cs_sel);
                  edge_cnt  <= '0;
                  bit_count <= CNT_W'(DATA_WIDTH);
                  busy      <= 1'b1;
                  state     <= LEAD;
                  // With cpha=0 the slave samples on the first edge, so bit 0 must be set up now.
                  if (!cpha) spi_mosi <= head(datain, lsb_first);
               end
            end
            LEAD: begin
               div_cnt <= tick ? '0 : div_cnt + 1'b1;
               if (tick) state <= XFER;
            end
            XFER: begin
               div_cnt <= tick ? '0 : div_cnt + 1'b1;
               if (tick) begin
                  spi_sclk <= ~spi_sclk;
                  edge_cnt <= edge_cnt + 1'b1;
                  if (sample) begin
                     rx_sh     <= lsb_q ? {spi_miso, rx_sh[DATA_WIDTH-1:1]}
                                        : {rx_sh[DATA_WIDTH-2:0], spi_miso};
                     bit_count <= bit_count - 1'b1;
                  end else if (cpha_q) begin
                     // Leading edge of cpha=1: present the current head bit.
                     spi_mosi <= head(tx_sh, lsb_q);
                     tx_sh    <= shift(tx_sh, lsb_q);
                  end else begin
                     // Trailing edge of cpha=0: the current bit was already out, move to the next.
                     spi_mosi <= head(shift(tx_sh, lsb_q), lsb_q);
                     tx_sh    <= shift(tx_sh, lsb_q);
                  end
                  if (edge_cnt == EDGE_W'(2 * DATA_WIDTH - 1)) state <= TRAIL;
               end
            end
            TRAIL: begin
               div_cnt <= tick ? '0 : div_cnt + 1'b1;
               if (tick) begin
                  spi_cs_l  <= '1;
                  dataout   <= rx_sh;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  bit_count <= CNT_W'(DATA_WIDTH);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param
module tb_spi_master_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // u0: 16-bit, CLK_DIV=2, four chip selects
   logic        start0;
   logic [15:0] d0;
   logic [1:0]  sel0;
   logic        pol0, pha0, lsb0, miso0;
   logic        busy0, done0, sclk0, mosi0;
   logic [15:0] dout0;
   logic [3:0]  cs0;
   logic [4:0]  bc0;

   // u1: 8-bit, CLK_DIV=1, one chip select, miso looped to mosi
   logic        start1;
   logic [7:0]  d1;
   logic [0:0]  sel1;
   logic        pol1, pha1, lsb1, miso1;
   logic        busy1, done1, sclk1, mosi1;
   logic [7:0]  dout1;
   logic [0:0]  cs1;
   logic [3:0]  bc1;

   int checks = 0;
   int errors = 0;
   int ndone0 = 0;
   int ndone1 = 0;
   int rise0  = 0;
   int tog1   = 0;
   logic arm0 = 1'b0;
   logic arm1 = 1'b0;

   logic [15:0] sb0[$];
   logic [7:0]  sb1[$];
   logic [15:0] exp0;
   logic [7:0]  exp1;

   // Slave model for cpha=1, LSB-first traffic on u0
   logic        loop0 = 1'b1;
   logic        sl_arm = 1'b0;
   logic        sl_miso = 1'b0;
   logic [15:0] sl_word = '0;
   logic [15:0] sl_rx = '0;
   int          sl_edge = 0;
   int          sl_drv = 0;
   int          sl_cap = 0;

   assign miso0 = loop0 ? mosi0 : sl_miso;
   assign miso1 = mosi1;

   spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(2), .NUM_CS(4)) u0 (
      .clk(clk), .reset(reset), .start(start0), .datain(d0), .cs_sel(sel0),
      .cpol(pol0), .cpha(pha0), .lsb_first(lsb0), .spi_miso(miso0),
      .busy(busy0), .done(done0), .dataout(dout0), .spi_cs_l(cs0),
      .spi_sclk(sclk0), .spi_mosi(mosi0), .bit_count(bc0)
   );

   spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(1), .NUM_CS(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .datain(d1), .cs_sel(sel1),
      .cpol(pol1), .cpha(pha1), .lsb_first(lsb1), .spi_miso(miso1),
      .busy(busy1), .done(done1), .dataout(dout1), .spi_cs_l(cs1),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .bit_count(bc1)
   );

   always @(posedge sclk0) if (arm0) rise0++;
   always @(sclk1) if (arm1) tog1++;

   always @(sclk0) begin
      if (sl_arm) begin
         sl_edge++;
         if (sl_edge % 2 == 1) begin
            if (sl_drv < 16) sl_miso = sl_word[sl_drv];
            sl_drv++;
         end else begin
            if (sl_cap < 16) sl_rx[sl_cap] = mosi0;
            sl_cap++;
         end
      end
   end

   // Scoreboard pop on done, plus a per-cycle chip-select sanity check
   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         ndone0++;
         checks++;
         if (sb0.size() == 0) begin
            errors++;
            $error("FAIL sb0_empty: done0 with dataout=%h, required no done", dout0);
         end else begin
            exp0 = sb0.pop_front();
            assert (dout0 === exp0) else begin
               errors++;
               $error("FAIL dataout0: got %h want %h", dout0, exp0);
            end
         end
      end
      if (done1 === 1'b1) begin
         ndone1++;
         checks++;
         if (sb1.size() == 0) begin
            errors++;
            $error("FAIL sb1_empty: done1 with dataout=%h, required no done", dout1);
         end else begin
            exp1 = sb1.pop_front();
            assert (dout1 === exp1) else begin
               errors++;
               $error("FAIL dataout1: got %h want %h", dout1, exp1);
            end
         end
      end
      if (reset === 1'b0) begin
         checks++;
         assert ($countones(~cs0) <= 1) else begin
            errors++;
            $error("FAIL cs0_onehot: got %b want at most one low", cs0);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic go0(input logic [15:0] d, input logic [1:0] s, input logic p, input logic h,
                      input logic l, input logic [15:0] expw);
      d0 = d; sel0 = s; pol0 = p; pha0 = h; lsb0 = l; start0 = 1'b1;
      sb0.push_back(expw);
      @(negedge clk);
      start0 = 1'b0;
      chk("busy0_rise", 32'(busy0), 32'd1);
   endtask

   task automatic wait0(output int bc);
      bc = 0;
      while (busy0 === 1'b1 && bc < 2000) begin
         bc++;
         @(negedge clk);
      end
      chk("done0_after_busy", 32'(done0), 32'd1);
   endtask

   int bc;
   int nd;

   initial begin
      reset = 1'b1;
      start0 = 1'b0; d0 = '0; sel0 = '0; pol0 = 1'b0; pha0 = 1'b0; lsb0 = 1'b0;
      start1 = 1'b0; d1 = '0; sel1 = '0; pol1 = 1'b0; pha1 = 1'b0; lsb1 = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_dataout", 32'(dout0), 32'd0);
      chk("rst_cs", 32'(cs0), 32'hF);
      chk("rst_sclk", 32'(sclk0), 32'd0);
      chk("rst_mosi", 32'(mosi0), 32'd0);
      chk("rst_bitcount", 32'(bc0), 32'd16);
      chk("rst_bitcount1", 32'(bc1), 32'd8);
      reset = 1'b0;
      @(negedge clk);

      // Mode 0, MSB first, loopback
      nd = ndone0; rise0 = 0; arm0 = 1'b1;
      go0(16'hA569, 2'd0, 1'b0, 1'b0, 1'b0, 16'hA569);
      chk("t1_cs", 32'(cs0), 32'hE);
      wait0(bc);
      arm0 = 1'b0;
      chk("t1_busy_len", 32'(bc), 32'd68);
      chk("t1_rises", 32'(rise0), 32'd16);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done0), 32'd0);
      chk("t1_done_count", 32'(ndone0 - nd), 32'd1);

      // Mode 3, LSB first, slave drives 2563 on cs 2
      loop0 = 1'b0; sl_word = 16'h2563; sl_rx = '0; sl_edge = 0; sl_drv = 0; sl_cap = 0; sl_miso = 1'b0;
      go0(16'h1234, 2'd2, 1'b1, 1'b1, 1'b1, 16'h2563);
      sl_arm = 1'b1;
      chk("t2_cs", 32'(cs0), 32'hB);
      chk("t2_sclk_lead", 32'(sclk0), 32'd1);
      wait0(bc);
      sl_arm = 1'b0;
      chk("t2_busy_len", 32'(bc), 32'd68);
      chk("t2_mosi_word", 32'(sl_rx), 32'h1234);
      chk("t2_sclk_idle", 32'(sclk0), 32'd1);
      chk("t2_cs_idle", 32'(cs0), 32'hF);
      loop0 = 1'b1;
      @(negedge clk);

      // Start during a transfer is ignored
      nd = ndone0;
      go0(16'h3C5A, 2'd0, 1'b0, 1'b0, 1'b0, 16'h3C5A);
      repeat (29) @(negedge clk);
      d0 = 16'h9B63; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("t3_busy_hold", 32'(busy0), 32'd1);
      wait0(bc);
      chk("t3_busy_rest", 32'(bc), 32'd38);
      repeat (4) @(negedge clk);
      chk("t3_done_count", 32'(ndone0 - nd), 32'd1);
      chk("t3_no_restart", 32'(busy0), 32'd0);

      // Reset mid-transfer
      nd = ndone0;
      go0(16'h5AA5, 2'd1, 1'b0, 1'b0, 1'b0, 16'h5AA5);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      void'(sb0.pop_back());
      @(negedge clk);
      chk("t4_cs", 32'(cs0), 32'hF);
      chk("t4_busy", 32'(busy0), 32'd0);
      chk("t4_bitcount", 32'(bc0), 32'd16);
      chk("t4_done", 32'(done0), 32'd0);
      chk("t4_dataout", 32'(dout0), 32'd0);
      chk("t4_sclk", 32'(sclk0), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("t4_no_done", 32'(ndone0 - nd), 32'd0);
      go0(16'hC3E1, 2'd3, 1'b0, 1'b0, 1'b0, 16'hC3E1);
      wait0(bc);
      chk("t4_fresh_len", 32'(bc), 32'd68);

      // Back-to-back: start in the done cycle
      go0(16'h0F0F, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0F0F);
      wait0(bc);
      go0(16'h6A61, 2'd1, 1'b0, 1'b0, 1'b0, 16'h6A61);
      chk("t5_cs", 32'(cs0), 32'hD);
      wait0(bc);
      chk("t5_busy_len", 32'(bc), 32'd68);
      @(negedge clk);

      // u1: 8-bit, CLK_DIV=1, mode 2, loopback
      d1 = 8'hA2; pol1 = 1'b1; pha1 = 1'b0; lsb1 = 1'b0; sel1 = 1'b0; start1 = 1'b1;
      sb1.push_back(8'hA2);
      @(negedge clk);
      start1 = 1'b0;
      chk("t6_busy_rise", 32'(busy1), 32'd1);
      chk("t6_cs", 32'(cs1), 32'd0);
      tog1 = 0; arm1 = 1'b1;
      bc = 0;
      while (busy1 === 1'b1 && bc < 2000) begin
         bc++;
         @(negedge clk);
      end
      arm1 = 1'b0;
      chk("t6_busy_len", 32'(bc), 32'd18);
      chk("t6_toggles", 32'(tog1), 32'd16);
      chk("t6_done", 32'(done1), 32'd1);
      @(negedge clk);
      chk("t6_sclk_idle", 32'(sclk1), 32'd1);
      chk("t6_done_count", 32'(ndone1), 32'd1);
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
